// File: rtl/sd_acq_pkg.sv
// Shared types and default widths for the acquisition sampler slice.
package sd_acq_pkg;

    localparam int unsigned DEF_DIVW = 8;
    localparam int unsigned DEF_CNTW = 16;
    localparam int unsigned DEF_WINW = 4;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        WIN  = 4'b0010,
        GAP  = 4'b0100,
        DONE = 4'b1000
    } state_e;

endpackage

// File: rtl/sd_acq_divider.sv
// Sample-period divider: latches the period on clr, then emits a registered strobe
// every period cycles while run is high. tick_o marks the edge that raises the strobe.
module sd_acq_divider
    import sd_acq_pkg::*;
#(
    parameter int unsigned DIVW = DEF_DIVW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            run_i,
    input  logic [DIVW-1:0] period_i,
    output logic            tick_o,
    output logic            strobe_o
);

    localparam logic [DIVW-1:0] ONE = DIVW'(1);

    logic [DIVW-1:0] period_q, period_d;
    logic [DIVW-1:0] phase_q, phase_d;
    logic            strobe_q, strobe_d;

    always_comb begin
        period_d = period_q;
        phase_d  = phase_q;
        strobe_d = 1'b0;
        tick_o   = 1'b0;
        if (clr_i) begin
            // A zero period would never wrap; run it as one sample per cycle.
            period_d = (period_i == '0) ? ONE : period_i;
            phase_d  = '0;
        end else if (run_i) begin
            if (phase_q == period_q - ONE) begin
                tick_o   = 1'b1;
                strobe_d = 1'b1;
                phase_d  = '0;
            end else begin
                phase_d = phase_q + ONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            period_q <= ONE;
            phase_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            period_q <= period_d;
            phase_q  <= phase_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/sd_acq_sampler.sv
// Turns sequencer en windows into ADC sample strobes, counts samples per window and
// per sequence, and reports window closes and sequence completion.
module sd_acq_sampler
    import sd_acq_pkg::*;
#(
    parameter int unsigned DIVW = DEF_DIVW,
    parameter int unsigned CNTW = DEF_CNTW,
    parameter int unsigned WINW = DEF_WINW
) (
    input  logic            dds,
    input  logic            rst,
    input  logic            en,
    input  logic            stateover,
    input  logic [DIVW-1:0] div,
    output logic            sample_strobe,
    output logic [CNTW-1:0] sample_idx,
    output logic [WINW-1:0] win_idx,
    output logic            win_valid,
    output logic [CNTW-1:0] win_len,
    output logic [CNTW-1:0] total_samples,
    output logic            busy,
    output logic            done,
    output logic            overflow
);

    state_e          state_q, state_d;
    logic            en_q;
    logic            rise, fall;
    logic            in_win, div_clr, tick;
    logic [CNTW-1:0] sample_idx_q, sample_idx_d;
    logic [CNTW-1:0] total_q, total_d;
    logic [WINW-1:0] win_idx_q, win_idx_d;
    logic [CNTW-1:0] win_len_q, win_len_d;
    logic            win_valid_q, win_valid_d;
    logic            done_q, done_d;
    logic            overflow_q, overflow_d;

    assign rise   = en & ~en_q;
    assign fall   = ~en & en_q;
    assign in_win = (state_q == WIN);

    sd_acq_divider #(
        .DIVW(DIVW)
    ) u_div (
        .clk_i   (dds),
        .rst_i   (rst),
        .clr_i   (div_clr),
        .run_i   (in_win),
        .period_i(div),
        .tick_o  (tick),
        .strobe_o(sample_strobe)
    );

    always_comb begin
        state_d      = state_q;
        sample_idx_d = sample_idx_q;
        total_d      = total_q;
        win_idx_d    = win_idx_q;
        win_len_d    = win_len_q;
        win_valid_d  = 1'b0;
        done_d       = 1'b0;
        overflow_d   = overflow_q;
        div_clr      = 1'b0;

        // Counting precedes the FSM so a strobe on the closing edge lands in win_len.
        if (tick) begin
            if (sample_idx_q == '1) overflow_d = 1'b1;
            else                    sample_idx_d = sample_idx_q + CNTW'(1);
            if (total_q == '1) overflow_d = 1'b1;
            else               total_d = total_q + CNTW'(1);
        end

        case (state_q)
            IDLE: begin
                if (rise && stateover) begin
                    state_d      = WIN;
                    div_clr      = 1'b1;
                    sample_idx_d = '0;
                end
            end
            WIN: begin
                if (fall || !stateover) begin
                    win_valid_d = 1'b1;
                    win_len_d   = sample_idx_d;
                    if (stateover) begin
                        state_d = GAP;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (!stateover) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (rise) begin
                    if (win_idx_q == '1) begin
                        overflow_d = 1'b1;
                    end else begin
                        state_d      = WIN;
                        win_idx_d    = win_idx_q + WINW'(1);
                        div_clr      = 1'b1;
                        sample_idx_d = '0;
                    end
                end
            end
            DONE: begin
                if (stateover && !en) begin
                    state_d      = IDLE;
                    sample_idx_d = '0;
                    total_d      = '0;
                    win_idx_d    = '0;
                    overflow_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge dds or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            en_q         <= 1'b0;
            sample_idx_q <= '0;
            total_q      <= '0;
            win_idx_q    <= '0;
            win_len_q    <= '0;
            win_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_q         <= en;
            sample_idx_q <= sample_idx_d;
            total_q      <= total_d;
            win_idx_q    <= win_idx_d;
            win_len_q    <= win_len_d;
            win_valid_q  <= win_valid_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign sample_idx    = sample_idx_q;
    assign win_idx       = win_idx_q;
    assign win_valid     = win_valid_q;
    assign win_len       = win_len_q;
    assign total_samples = total_q;
    assign busy          = (state_q == WIN) || (state_q == GAP);
    assign done          = done_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_sd_acq_sampler.sv
// Directed bench for sd_acq_sampler with narrow counters so saturation and window limits are reachable.
module tb_sd_acq_sampler;

    localparam int unsigned DIVW = 8;
    localparam int unsigned CNTW = 4;
    localparam int unsigned WINW = 2;

    logic            dds = 1'b0;
    logic            rst;
    logic            en;
    logic            stateover;
    logic [DIVW-1:0] div;
    logic            sample_strobe;
    logic [CNTW-1:0] sample_idx;
    logic [WINW-1:0] win_idx;
    logic            win_valid;
    logic [CNTW-1:0] win_len;
    logic [CNTW-1:0] total_samples;
    logic            busy;
    logic            done;
    logic            overflow;

    int n_cmp = 0;
    int n_err = 0;

    sd_acq_sampler #(
        .DIVW(DIVW),
        .CNTW(CNTW),
        .WINW(WINW)
    ) dut (
        .dds          (dds),
        .rst          (rst),
        .en           (en),
        .stateover    (stateover),
        .div          (div),
        .sample_strobe(sample_strobe),
        .sample_idx   (sample_idx),
        .win_idx      (win_idx),
        .win_valid    (win_valid),
        .win_len      (win_len),
        .total_samples(total_samples),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 dds = ~dds;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge dds);
            #1;
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({sample_strobe, sample_idx, win_idx, win_valid, win_len,
                    total_samples, busy, done, overflow});
    endfunction

    // Opens a window, holds it for len edges after entry, closes by en fall or stateover drop.
    // spat/vpat bit n-1 hold sample_strobe/win_valid in the cycle after entry edge + n.
    task automatic run_win(input logic [DIVW-1:0] d, input int unsigned len, input logic drop_so,
                           output logic [31:0] spat, output logic [31:0] vpat);
        div = d;
        en  = 1'b1;
        step(1);
        div  = 8'd1;
        spat = '0;
        vpat = '0;
        for (int unsigned n = 1; n <= len; n++) begin
            if (n == len) begin
                if (drop_so) stateover = 1'b0;
                else         en = 1'b0;
            end
            step(1);
            spat[n-1] = sample_strobe;
            vpat[n-1] = win_valid;
        end
    endtask

    task automatic end_seq(input string tag);
        stateover = 1'b0;
        step(1);
        expect_eq({tag, ".done"}, 32'(done), 32'd1);
        step(1);
        expect_eq({tag, ".done_pulse"}, 32'(done), 32'd0);
        stateover = 1'b1;
        en = 1'b0;
        step(1);
    endtask

    logic [31:0] sp, vp;

    initial begin
        rst = 1'b1;
        en = 1'b0;
        stateover = 1'b1;
        div = 8'd4;
        #3;
        expect_eq("reset.outs", all_outs(), 32'd0);
        step(2);
        rst = 1'b0;
        step(1);
        expect_eq("idle.outs", all_outs(), 32'd0);

        // 1: single window, div=4, 20 cycles
        run_win(8'd4, 20, 1'b0, sp, vp);
        expect_eq("t1.strobes", sp, 32'h88888);
        expect_eq("t1.valid", vp, 32'h80000);
        expect_eq("t1.win_len", 32'(win_len), 32'd5);
        expect_eq("t1.total", 32'(total_samples), 32'd5);
        expect_eq("t1.busy_gap", 32'(busy), 32'd1);
        stateover = 1'b0;
        step(1);
        expect_eq("t1.done", 32'(done), 32'd1);
        expect_eq("t1.busy_done", 32'(busy), 32'd0);
        expect_eq("t1.total_done", 32'(total_samples), 32'd5);
        step(1);
        expect_eq("t1.done_pulse", 32'(done), 32'd0);
        stateover = 1'b1;
        step(1);
        expect_eq("t1.idle_total", 32'(total_samples), 32'd0);

        // 2: two windows, div=3, lengths 9 and 7
        run_win(8'd3, 9, 1'b0, sp, vp);
        expect_eq("t2.w0_strobes", sp, 32'h124);
        expect_eq("t2.w0_valid", vp, 32'h100);
        expect_eq("t2.w0_len", 32'(win_len), 32'd3);
        expect_eq("t2.w0_idx", 32'(win_idx), 32'd0);
        step(4);
        expect_eq("t2.gap_busy", 32'(busy), 32'd1);
        expect_eq("t2.gap_valid", 32'(win_valid), 32'd0);
        expect_eq("t2.gap_len_held", 32'(win_len), 32'd3);
        run_win(8'd3, 7, 1'b0, sp, vp);
        expect_eq("t2.w1_strobes", sp, 32'h24);
        expect_eq("t2.w1_valid", vp, 32'h40);
        expect_eq("t2.w1_len", 32'(win_len), 32'd2);
        expect_eq("t2.w1_idx", 32'(win_idx), 32'd1);
        expect_eq("t2.total", 32'(total_samples), 32'd5);
        end_seq("t2");

        // 3: div=0 behaves as div=1
        run_win(8'd0, 6, 1'b0, sp, vp);
        expect_eq("t3.strobes", sp, 32'h3F);
        expect_eq("t3.valid", vp, 32'h20);
        expect_eq("t3.win_len", 32'(win_len), 32'd6);
        end_seq("t3");

        // 4: stateover drops while en still high
        run_win(8'd4, 10, 1'b1, sp, vp);
        expect_eq("t4.strobes", sp, 32'h88);
        expect_eq("t4.valid", vp, 32'h200);
        expect_eq("t4.win_len", 32'(win_len), 32'd2);
        expect_eq("t4.done", 32'(done), 32'd1);
        expect_eq("t4.no_gap", 32'(busy), 32'd0);
        step(1);
        expect_eq("t4.done_pulse", 32'(done), 32'd0);
        stateover = 1'b1;
        en = 1'b0;
        step(1);
        expect_eq("t4.idle_busy", 32'(busy), 32'd0);

        // 5: counter saturation at 4 bits
        run_win(8'd1, 20, 1'b0, sp, vp);
        expect_eq("t5.strobes", sp, 32'hFFFFF);
        expect_eq("t5.sample_idx", 32'(sample_idx), 32'd15);
        expect_eq("t5.win_len", 32'(win_len), 32'd15);
        expect_eq("t5.total", 32'(total_samples), 32'd15);
        expect_eq("t5.overflow", 32'(overflow), 32'd1);
        stateover = 1'b0;
        step(1);
        expect_eq("t5.overflow_done", 32'(overflow), 32'd1);
        stateover = 1'b1;
        step(1);
        expect_eq("t5.overflow_idle", 32'(overflow), 32'd0);
        expect_eq("t5.total_idle", 32'(total_samples), 32'd0);

        // window limit: indices 0..3 accepted, a fifth rise stays in GAP
        for (int unsigned w = 0; w < 4; w++) begin
            run_win(8'd1, 1, 1'b0, sp, vp);
            expect_eq("wl.strobe", sp, 32'h1);
            step(1);
        end
        expect_eq("wl.idx", 32'(win_idx), 32'd3);
        expect_eq("wl.total", 32'(total_samples), 32'd4);
        expect_eq("wl.no_ovf", 32'(overflow), 32'd0);
        en = 1'b1;
        step(3);
        expect_eq("wl.ovf", 32'(overflow), 32'd1);
        expect_eq("wl.idx_held", 32'(win_idx), 32'd3);
        expect_eq("wl.busy", 32'(busy), 32'd1);
        expect_eq("wl.no_strobe", 32'(sample_strobe), 32'd0);
        expect_eq("wl.idx_sample", 32'(sample_idx), 32'd1);
        en = 1'b0;
        end_seq("wl");

        // 6: asynchronous reset mid-window
        run_win(8'd2, 4, 1'b0, sp, vp);
        expect_eq("t6.w0_strobes", sp, 32'hA);
        step(1);
        div = 8'd2;
        en = 1'b1;
        step(4);
        expect_eq("t6.pre_idx", 32'(win_idx), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        expect_eq("t6.async_outs", all_outs(), 32'd0);
        en = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        expect_eq("t6.after_outs", all_outs(), 32'd0);
        run_win(8'd2, 4, 1'b0, sp, vp);
        expect_eq("t6.restart_strobes", sp, 32'hA);
        expect_eq("t6.restart_idx", 32'(win_idx), 32'd0);
        expect_eq("t6.restart_len", 32'(win_len), 32'd2);
        expect_eq("t6.restart_total", 32'(total_samples), 32'd2);
        end_seq("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
